pattern_scheduler: RTL and testbench
====================================

PATTERN_SCHEDULER -- requirements
Module: pattern_scheduler

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000; sample period of the key debouncer in clk cycles (2.5 ms at 100 MHz); legal range 2..2^20.
REQ-002 Parameter NUM_PATTERNS, default 5; number of selectable bitwise patterns (OR, XOR, AND, NAND, XNOR).
REQ-003 clk  input  1  single system clock (100 MHz); all logic in this one domain.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 key  input  9  raw, unsynchronised compare-value keys, active-high.
REQ-006 btn_next  input  1  raw pushbutton, active-high; requests the next pattern in manual mode.
REQ-007 btn_mode  input  1  raw pushbutton, active-high; toggles manual/auto mode.
REQ-008 frame_start  input  1  one-cycle pulse at the start of vertical blanking, from the timing generator.
REQ-009 tick  input  1  one-cycle tempo pulse (half-second); drives auto-advance.
REQ-010 pattern_sel  output  3  selected pattern index, 0..NUM_PATTERNS-1.
REQ-011 key_mask  output  9  debounced key value, frame-latched.
REQ-012 auto_mode  output  1  1 = auto-advance mode, 0 = manual mode.
REQ-013 update  output  1  one-cycle pulse in the cycle pattern_sel takes a new value.

Function
REQ-014 key, btn_next and btn_mode SHALL each pass through a 2-flop synchroniser before any other use.
REQ-015 A shared sample counter SHALL count 0..DEBOUNCE_CYCLES-1 and wrap; the wrap cycle is the sample strobe.
REQ-016 At each strobe, each debounced bit SHALL take its synchronised value when that value equals the previous strobe's sample; otherwise the bit holds.
REQ-017 A rising edge of debounced btn_mode SHALL toggle auto_mode on the next cycle and clear the pending flag.
REQ-018 In MANUAL, a rising edge of debounced btn_next SHALL set pending; in AUTO, tick SHALL set pending; the other source is ignored.
REQ-019 FSM states: IDLE (after reset, waits for the first frame_start), MANUAL, AUTO; IDLE->MANUAL on the first frame_start; MANUAL<->AUTO per REQ-017.
REQ-020 When frame_start=1 and pending=1 (outside IDLE), pattern_sel SHALL advance by one on the following cycle; update SHALL pulse in that same cycle; pending SHALL clear.
REQ-021 pattern_sel SHALL wrap from NUM_PATTERNS-1 to 0; values >= NUM_PATTERNS are never produced.
REQ-022 A pending set in the same cycle as frame_start SHALL NOT be applied at that frame_start; it is applied at the next frame_start.
REQ-023 Multiple pending events within one frame SHALL produce exactly one advance.
REQ-024 key_mask SHALL load the debounced key value one cycle after every frame_start (IDLE included), and SHALL never change between frame_starts.
REQ-025 A mode toggle in the same cycle as frame_start SHALL take priority: the toggle applies, pending clears, and no advance occurs.
REQ-026 update SHALL be 0 in every cycle in which pattern_sel does not change.

Reset
REQ-027 While reset=0: state=IDLE, pattern_sel=0, key_mask=0, auto_mode=0, update=0, pending=0, sample counter=0, all synchroniser and debounce flops=0.
REQ-028 Reset assertion mid-operation SHALL clear all state asynchronously; after release, the block SHALL return to IDLE and wait for a fresh frame_start.

Structure
REQ-029 Shared package pattern_pkg SHALL hold the pattern index constants (OR=0, XOR=1, AND=2, NAND=3, XNOR=4), NUM_PATTERNS, and the FSM state encoding.
REQ-030 The synchroniser and debounce logic SHALL be one width-parameterised sub-module, key_debounce, instantiated once for {btn_mode, btn_next, key}; the strobe counter lives inside it.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Reset, then frame_start -> state MANUAL, pattern_sel=0, key_mask=0, update=0 throughout.
REQ-032 btn_next held high for 12 cycles, then frame_start -> pattern_sel 0->1 one cycle after frame_start with a single update pulse; a second frame_start without a press leaves pattern_sel=1.
REQ-033 Five btn_next presses, each followed by a frame_start -> pattern_sel sequence 1,2,3,4,0 (wrap).
REQ-034 btn_mode press, then three ticks in one frame, then frame_start -> auto_mode=1 and exactly one advance; a btn_next press in AUTO causes no advance.
REQ-035 key toggling 9'h0AA/9'h155 every cycle for 40 cycles, then stable at 9'h1F0 -> key_mask=9'h1F0 only after the first frame_start following two equal samples; it never shows a glitch value.
REQ-036 tick coincident with frame_start in AUTO -> no advance at that frame_start; advance at the next one; reset asserted mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared constants for the pattern scheduler: pattern indices,
// pattern count, FSM encoding and the index wrap helper.
package pattern_pkg;

  localparam int NUM_PATTERNS = 5;

  localparam logic [2:0] PAT_OR   = 3'd0;
  localparam logic [2:0] PAT_XOR  = 3'd1;
  localparam logic [2:0] PAT_AND  = 3'd2;
  localparam logic [2:0] PAT_NAND = 3'd3;
  localparam logic [2:0] PAT_XNOR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_AUTO   = 2'd2
  } state_t;

  function automatic logic [2:0] next_pat(
    input logic [2:0] p,
    input int         n
  );
    return (int'(p) >= n - 1) ? 3'd0 : p + 3'd1;
  endfunction

endpackage

// File: rtl/pattern_scheduler_key_debounce.sv
// 2-flop synchroniser plus strobe-sampled debouncer, W bits wide.
// Ports: clk, rst_n, i_raw[W] raw inputs, o_deb[W] debounced outputs.
module key_debounce #(
  parameter int W   = 11,
  parameter int CYC = 250000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_raw,
  output logic [W-1:0] o_deb
);

  localparam int CW = (CYC > 1) ? $clog2(CYC) : 1;

  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_s1;
  logic [W-1:0]  r_s2;
  logic [W-1:0]  r_prev;
  logic [W-1:0]  r_deb;
  logic          w_strobe;
  logic [W-1:0]  w_agree;

  assign w_strobe = (r_cnt == CW'(CYC - 1));
  // A bit may only move when two successive samples agree.
  assign w_agree  = ~(r_s2 ^ r_prev);
  assign o_deb    = r_deb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
      r_deb  <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      r_cnt <= w_strobe ? '0 : r_cnt + 1'b1;
      if (w_strobe) begin
        r_prev <= r_s2;
        r_deb  <= (r_s2 & w_agree) | (r_deb & ~w_agree);
      end
    end
  end

endmodule

// File: rtl/pattern_scheduler.sv
// Selects a bitwise pattern, advancing at frame starts on button or tempo.
// Ports: clk, reset(n), key, btn_next, btn_mode, frame_start, tick -> pattern_sel, key_mask, auto_mode, update.
module pattern_scheduler #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int NUM_PATTERNS    = pattern_pkg::NUM_PATTERNS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] key,
  input  logic       btn_next,
  input  logic       btn_mode,
  input  logic       frame_start,
  input  logic       tick,
  output logic [2:0] pattern_sel,
  output logic [8:0] key_mask,
  output logic       auto_mode,
  output logic       update
);

  import pattern_pkg::*;

  logic [10:0] w_deb;
  logic [8:0]  w_key;
  logic        w_next;
  logic        w_mode;
  logic        r_next_d;
  logic        r_mode_d;
  logic        w_next_rise;
  logic        w_mode_rise;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_pend;
  logic        w_pend_nxt;
  logic        w_set;
  logic        w_adv;
  logic        r_upd;
  logic [2:0]  r_sel;
  logic [8:0]  r_mask;

  key_debounce #(
    .W   (11),
    .CYC (DEBOUNCE_CYCLES)
  ) u_deb (
    .clk   (clk),
    .rst_n (reset),
    .i_raw ({btn_mode, btn_next, key}),
    .o_deb (w_deb)
  );

  assign w_key       = w_deb[8:0];
  assign w_next      = w_deb[9];
  assign w_mode      = w_deb[10];
  assign w_next_rise = w_next & ~r_next_d;
  assign w_mode_rise = w_mode & ~r_mode_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (frame_start) w_state_nxt = ST_MANUAL;
      ST_MANUAL: if (w_mode_rise) w_state_nxt = ST_AUTO;
      ST_AUTO:   if (w_mode_rise) w_state_nxt = ST_MANUAL;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // A mode toggle wins over an advance. Events arriving with a
  // frame_start belong to the following frame.
  always_comb begin
    w_set = ((r_state == ST_MANUAL) & w_next_rise)
          | ((r_state == ST_AUTO) & tick);
    w_adv = 1'b0;
    w_pend_nxt = 1'b0;
    if (r_state != ST_IDLE && !w_mode_rise) begin
      w_adv      = frame_start & r_pend;
      w_pend_nxt = frame_start ? w_set : (r_pend | w_set);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_next_d <= 1'b0;
      r_mode_d <= 1'b0;
      r_pend   <= 1'b0;
      r_upd    <= 1'b0;
      r_sel    <= '0;
      r_mask   <= '0;
    end else begin
      r_next_d <= w_next;
      r_mode_d <= w_mode;
      r_pend   <= w_pend_nxt;
      r_upd    <= w_adv;
      if (w_adv) r_sel <= next_pat(r_sel, NUM_PATTERNS);
      if (frame_start) r_mask <= w_key;
    end
  end

  assign pattern_sel = r_sel;
  assign key_mask    = r_mask;
  assign auto_mode   = (r_state == ST_AUTO);
  assign update      = r_upd;

endmodule

// File: tb/tb_pattern_scheduler.sv
// Scoreboard bench for pattern_scheduler with DEBOUNCE_CYCLES=4.
// Stimulus queues expected pattern_sel values; a monitor checks updates.
module tb_pattern_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] key = '0;
  logic       btn_next = 1'b0;
  logic       btn_mode = 1'b0;
  logic       frame_start = 1'b0;
  logic       tick = 1'b0;
  logic [2:0] pattern_sel;
  logic [8:0] key_mask;
  logic       auto_mode;
  logic       update;

  int total = 0;
  int bad = 0;
  int m_sel = 0;
  logic [2:0] exp_q[$];

  logic [2:0] p_sel = '0;
  logic [8:0] p_mask = '0;
  logic       p_fs = 1'b0;

  always #5 clk = ~clk;

  pattern_scheduler #(
    .DEBOUNCE_CYCLES (4),
    .NUM_PATTERNS    (5)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .key         (key),
    .btn_next    (btn_next),
    .btn_mode    (btn_mode),
    .frame_start (frame_start),
    .tick        (tick),
    .pattern_sel (pattern_sel),
    .key_mask    (key_mask),
    .auto_mode   (auto_mode),
    .update      (update)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      p_sel  <= '0;
      p_mask <= '0;
      p_fs   <= 1'b0;
    end else begin
      if (update) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL update: unexpected pulse, sel=%0d", pattern_sel);
        end else begin
          logic [2:0] e;
          e = exp_q.pop_front();
          if (pattern_sel != e) begin
            bad++;
            $display("FAIL sel_on_update: got %0d expected %0d", pattern_sel, e);
          end
        end
      end else if (pattern_sel != p_sel) begin
        total++;
        bad++;
        $display("FAIL silent_change: sel %0d -> %0d without update", p_sel, pattern_sel);
      end
      if (key_mask != p_mask && !p_fs) begin
        total++;
        bad++;
        $display("FAIL mask_glitch: %0h -> %0h between frames", p_mask, key_mask);
      end
      p_sel  <= pattern_sel;
      p_mask <= key_mask;
      p_fs   <= frame_start;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame(input logic t = 1'b0);
    frame_start = 1'b1;
    tick = t;
    step();
    frame_start = 1'b0;
    tick = 1'b0;
    step(3);
  endtask

  task automatic press_next();
    btn_next = 1'b1;
    step(12);
    btn_next = 1'b0;
    step(12);
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    step(12);
    btn_mode = 1'b0;
    step(12);
  endtask

  task automatic advance_expect();
    m_sel = (m_sel + 1) % 5;
    exp_q.push_back(3'(m_sel));
  endtask

  initial begin
    step(3);
    chk("rst_sel", pattern_sel, 0);
    chk("rst_mask", key_mask, 0);
    chk("rst_auto", auto_mode, 0);
    chk("rst_upd", update, 0);
    rst_n = 1'b1;
    step(4);

    frame();
    chk("first_sel", pattern_sel, 0);
    chk("first_mask", key_mask, 0);
    chk("first_auto", auto_mode, 0);

    press_next();
    advance_expect();
    frame();
    chk("adv1_sel", pattern_sel, 1);
    frame();
    chk("no_press_sel", pattern_sel, 1);

    for (int i = 0; i < 5; i++) begin
      press_next();
      advance_expect();
      frame();
      chk("seq_sel", pattern_sel, m_sel);
    end
    chk("wrap_seen", m_sel, 1);

    press_mode();
    chk("auto_on", auto_mode, 1);
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step(2);
    end
    advance_expect();
    frame();
    chk("auto_one_adv", pattern_sel, 2);
    press_next();
    frame();
    chk("auto_ignores_btn", pattern_sel, 2);

    for (int i = 0; i < 40; i++) begin
      key = (i % 2 == 0) ? 9'h0AA : 9'h155;
      step();
    end
    key = 9'h1F0;
    chk("mask_hold_toggle", key_mask, 0);
    step(14);
    chk("mask_hold_stable", key_mask, 0);
    frame();
    chk("mask_load", key_mask, 9'h1F0);

    frame(1'b1);
    chk("tick_same_frame", pattern_sel, 2);
    advance_expect();
    frame();
    chk("tick_next_frame", pattern_sel, 3);
    chk("queue_drained", exp_q.size(), 0);

    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", pattern_sel, 0);
    chk("mid_rst_mask", key_mask, 0);
    chk("mid_rst_auto", auto_mode, 0);
    chk("mid_rst_upd", update, 0);
    m_sel = 0;
    step(3);
    rst_n = 1'b1;
    step(2);
    press_next();
    chk("idle_no_adv", pattern_sel, 0);
    frame();
    chk("idle_exit_sel", pattern_sel, 0);
    chk("idle_exit_mask", key_mask, 9'h1F0);
    press_next();
    advance_expect();
    frame();
    chk("post_rst_adv", pattern_sel, 1);
    step(4);
    chk("final_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
